// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch controller.
//   state_t    : controller FSM states
//   bcd_time_t : MM:SS as four BCD digits, most significant first
//   *_MOD      : digit moduli for the fixed-range digits. The minute-tens
//                modulus comes from the top-level MAX_MIN_TENS parameter.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2,
    LAP     = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam int SEC_ONES_MOD = 10;
  localparam int SEC_TENS_MOD = 6;
  localparam int MIN_ONES_MOD = 10;

  localparam bcd_time_t TIME_ZERO = '0;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its environment
// (button synchronizers, timer block, 7-segment driver).
//
// Protocol: there is no valid/ready handshake. The buttons are synchronized
// levels, and a command is the rising edge of a level. second_tick and
// overflow are single-cycle pulses. Every other output is a registered level
// that stays stable between clock edges.
//
//   master : the controller (consumes buttons/tick, drives timer + display)
//   slave  : the environment side
interface stopwatch_ctrl_if;

  logic                       start_stop_btn;
  logic                       clear_btn;
  logic                       lap_btn;
  logic                       second_tick;
  logic                       timer_enable;
  logic                       timer_n_clr;
  logic                       running;
  logic                       lap_hold;
  logic [3:0]                 disp_min_tens;
  logic [3:0]                 disp_min_ones;
  logic [3:0]                 disp_sec_tens;
  logic [3:0]                 disp_sec_ones;
  logic                       overflow;
  stopwatch_ctrl_pkg::state_t state_dbg;

  modport master (
    input  start_stop_btn, clear_btn, lap_btn, second_tick,
    output timer_enable, timer_n_clr, running, lap_hold,
    output disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones,
    output overflow, state_dbg
  );

  modport slave (
    output start_stop_btn, clear_btn, lap_btn, second_tick,
    input  timer_enable, timer_n_clr, running, lap_hold,
    input  disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones,
    input  overflow, state_dbg
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One BCD digit of the elapsed-time ripple chain.
//   clk, n_rst : clock and synchronous active-low reset
//   clr        : synchronous clear to 0. It has priority over inc.
//   inc        : advance by one. The digit wraps MODULUS-1 -> 0.
//   digit      : current value, which always stays in 0..MODULUS-1
//   carry      : combinational, inc & (digit == MODULUS-1). It feeds the next
//                digit's inc.
module bcd_digit_counter #(
  parameter int MODULUS = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] LAST = 4'(MODULUS - 1);

  assign carry = inc & (digit == LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM. It sequences the one-second timer block and keeps the
// elapsed time as MM:SS BCD.
//   clk   : system clock. All logic runs on its rising edge.
//   n_rst : synchronous active-low reset
//   bus   : stopwatch_ctrl_if.master. It carries the button levels,
//           second_tick, the timer enable/clear, the status flags, the BCD
//           display digits, the overflow pulse and the state_dbg state view.
// Parameters:
//   MAX_MIN_TENS : last minute-tens digit before wrap (5 -> 59:59)
//   RST_BTN_PREV : reset value of the edge-detect registers
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int   MAX_MIN_TENS = 5,
  parameter logic RST_BTN_PREV = 1'b1
) (
  input  logic              clk,
  input  logic              n_rst,
  stopwatch_ctrl_if.master  bus
);

  state_t    state;
  state_t    state_next;
  bcd_time_t count;
  bcd_time_t lap_latch;

  logic ss_prev, cl_prev, lp_prev;
  logic start_edge, clear_edge, lap_edge;

  logic timer_enable_q, timer_n_clr_q, running_q, lap_hold_q, overflow_q;

  // The edge registers follow the levels every cycle. Resetting them high
  // hides a button that is held through reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ss_prev <= RST_BTN_PREV;
      cl_prev <= RST_BTN_PREV;
      lp_prev <= RST_BTN_PREV;
    end else begin
      ss_prev <= bus.start_stop_btn;
      cl_prev <= bus.clear_btn;
      lp_prev <= bus.lap_btn;
    end
  end

  assign start_edge = bus.start_stop_btn & ~ss_prev;
  assign clear_edge = bus.clear_btn      & ~cl_prev;
  assign lap_edge   = bus.lap_btn        & ~lp_prev;

  // Ticks are honoured based on the state before the edge. A tick therefore
  // still counts in the cycle that moves RUNNING/LAP -> STOPPED.
  logic counting, tick_inc, cnt_clr;
  assign counting = (state == RUNNING) || (state == LAP);
  assign tick_inc = counting & bus.second_tick;
  assign cnt_clr  = (state == IDLE) || ((state == STOPPED) && clear_edge);

  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

  bcd_digit_counter #(.MODULUS(SEC_ONES_MOD)) u_sec_ones (
    .clk(clk), .n_rst(n_rst), .clr(cnt_clr), .inc(tick_inc),
    .digit(sec_ones), .carry(c_sec_ones)
  );

  bcd_digit_counter #(.MODULUS(SEC_TENS_MOD)) u_sec_tens (
    .clk(clk), .n_rst(n_rst), .clr(cnt_clr), .inc(c_sec_ones),
    .digit(sec_tens), .carry(c_sec_tens)
  );

  bcd_digit_counter #(.MODULUS(MIN_ONES_MOD)) u_min_ones (
    .clk(clk), .n_rst(n_rst), .clr(cnt_clr), .inc(c_sec_tens),
    .digit(min_ones), .carry(c_min_ones)
  );

  bcd_digit_counter #(.MODULUS(MAX_MIN_TENS + 1)) u_min_tens (
    .clk(clk), .n_rst(n_rst), .clr(cnt_clr), .inc(c_min_ones),
    .digit(min_tens), .carry(c_min_tens)
  );

  assign count = '{min_tens: min_tens, min_ones: min_ones,
                   sec_tens: sec_tens, sec_ones: sec_ones};

  // Next-state decode. Start has priority over lap while counting, and
  // clear has priority over start while stopped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_edge) state_next = RUNNING;
      RUNNING: if (start_edge)      state_next = STOPPED;
               else if (lap_edge)   state_next = LAP;
      LAP:     if (start_edge)      state_next = STOPPED;
               else if (lap_edge)   state_next = RUNNING;
      STOPPED: if (clear_edge)      state_next = IDLE;
               else if (start_edge) state_next = RUNNING;
      default: state_next = IDLE;
    endcase
  end

  // The outputs are registered from the next state, so they change in the
  // same cycle as the state register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state          <= IDLE;
      lap_latch      <= TIME_ZERO;
      timer_enable_q <= 1'b0;
      timer_n_clr_q  <= 1'b0;
      running_q      <= 1'b0;
      lap_hold_q     <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state <= state_next;
      // Capture the pre-tick count on entry to LAP.
      if ((state == RUNNING) && (state_next == LAP)) lap_latch <= count;
      timer_enable_q <= (state_next == RUNNING) || (state_next == LAP);
      timer_n_clr_q  <= (state_next != IDLE);
      running_q      <= (state_next == RUNNING) || (state_next == LAP);
      lap_hold_q     <= (state_next == LAP);
      overflow_q     <= c_min_tens;
    end
  end

  assign bus.timer_enable  = timer_enable_q;
  assign bus.timer_n_clr   = timer_n_clr_q;
  assign bus.running       = running_q;
  assign bus.lap_hold      = lap_hold_q;
  assign bus.overflow      = overflow_q;
  assign bus.state_dbg     = state;
  assign bus.disp_min_tens = lap_hold_q ? lap_latch.min_tens : count.min_tens;
  assign bus.disp_min_ones = lap_hold_q ? lap_latch.min_ones : count.min_ones;
  assign bus.disp_sec_tens = lap_hold_q ? lap_latch.sec_tens : count.sec_tens;
  assign bus.disp_sec_ones = lap_hold_q ? lap_latch.sec_ones : count.sec_ones;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl. A seconds-based reference model predicts every
// output for every cycle. Directed steps also check the documented scenarios
// against literal values.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  localparam int MAX_MIN_TENS = 5;
  localparam int WRAP_SECS    = (MAX_MIN_TENS + 1) * 600;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.MAX_MIN_TENS(MAX_MIN_TENS), .RST_BTN_PREV(1'b1)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [22:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [22:0] observed();
    return {bus.state_dbg, bus.disp_min_tens, bus.disp_min_ones,
            bus.disp_sec_tens, bus.disp_sec_ones, bus.timer_enable,
            bus.timer_n_clr, bus.running, bus.lap_hold, bus.overflow};
  endfunction

  function automatic logic [15:0] disp();
    return {bus.disp_min_tens, bus.disp_min_ones, bus.disp_sec_tens, bus.disp_sec_ones};
  endfunction

  // ---------------- reference model ----------------
  state_t m_state = IDLE;
  int     m_secs  = 0;
  int     m_lap   = 0;
  logic   m_ovf   = 1'b0;
  logic   m_pss = 1'b1, m_pcl = 1'b1, m_plp = 1'b1;

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_edge(input logic rst_n, input logic s, input logic c,
                            input logic l, input logic t);
    logic es, ec, el, busy;
    int   old;
    if (!rst_n) begin
      m_state = IDLE; m_secs = 0; m_lap = 0; m_ovf = 1'b0;
      m_pss = 1'b1; m_pcl = 1'b1; m_plp = 1'b1;
    end else begin
      es = s & ~m_pss; ec = c & ~m_pcl; el = l & ~m_plp;
      m_pss = s; m_pcl = c; m_plp = l;
      old   = m_secs;
      m_ovf = 1'b0;
      if ((m_state == RUNNING || m_state == LAP) && t) begin
        m_secs = m_secs + 1;
        if (m_secs == WRAP_SECS) begin m_secs = 0; m_ovf = 1'b1; end
      end
      case (m_state)
        IDLE:    if (es) m_state = RUNNING;
        RUNNING: if (es) m_state = STOPPED;
                 else if (el) begin m_lap = old; m_state = LAP; end
        LAP:     if (es) m_state = STOPPED;
                 else if (el) m_state = RUNNING;
        STOPPED: if (ec) begin m_state = IDLE; m_secs = 0; end
                 else if (es) m_state = RUNNING;
        default: m_state = IDLE;
      endcase
    end
    busy = (m_state == RUNNING) || (m_state == LAP);
    exp_q.push_back({m_state,
                     (m_state == LAP) ? to_bcd(m_lap) : to_bcd(m_secs),
                     busy, m_state != IDLE, busy, m_state == LAP, m_ovf});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic t);
    bus.second_tick = t;
    model_edge(n_rst, bus.start_stop_btn, bus.clear_btn, bus.lap_btn, t);
    @(posedge clk);
    #1;
    check("cycle_outputs", 32'(observed()), 32'(exp_q.pop_front()));
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic press(input logic s, input logic c, input logic l);
    bus.start_stop_btn = s; bus.clear_btn = c; bus.lap_btn = l;
    step(1'b0);
    bus.start_stop_btn = 1'b0; bus.clear_btn = 1'b0; bus.lap_btn = 1'b0;
    step(1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.start_stop_btn = 1'b0;
    bus.clear_btn      = 1'b0;
    bus.lap_btn        = 1'b0;
    bus.second_tick    = 1'b0;

    // Reset, then ticks without start.
    n_rst = 1'b0;
    step(1'b0);
    step(1'b0);
    check("reset_disp", 32'(disp()), 32'h0000);
    check("reset_nclr", 32'(bus.timer_n_clr), 32'd0);
    n_rst = 1'b1;
    ticks(3);
    check("idle_disp", 32'(disp()), 32'h0000);
    check("idle_en", 32'(bus.timer_enable), 32'd0);
    check("idle_nclr", 32'(bus.timer_n_clr), 32'd0);

    // Start, 75 ticks, stop -> 01:15 frozen.
    press(1'b1, 1'b0, 1'b0);
    check("run_en", 32'(bus.timer_enable), 32'd1);
    ticks(75);
    press(1'b1, 1'b0, 1'b0);
    check("stop_disp", 32'(disp()), 32'h0115);
    check("stop_en", 32'(bus.timer_enable), 32'd0);
    check("stop_state", 32'(bus.state_dbg), 32'(STOPPED));
    ticks(5);
    check("stop_hold_disp", 32'(disp()), 32'h0115);

    // Clear, run to 00:10, lap hold, then release.
    press(1'b0, 1'b1, 1'b0);
    check("clear_disp", 32'(disp()), 32'h0000);
    press(1'b1, 1'b0, 1'b0);
    ticks(10);
    press(1'b0, 1'b0, 1'b1);
    ticks(20);
    check("lap_disp", 32'(disp()), 32'h0010);
    check("lap_hold", 32'(bus.lap_hold), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("unlap_disp", 32'(disp()), 32'h0030);
    check("unlap_hold", 32'(bus.lap_hold), 32'd0);

    // Run to 59:58 and through the wrap.
    ticks(WRAP_SECS - 2 - 30);
    check("pre_wrap_disp", 32'(disp()), 32'h5958);
    ticks(1);
    check("last_disp", 32'(disp()), 32'h5959);
    check("no_ovf_yet", 32'(bus.overflow), 32'd0);
    ticks(1);
    check("wrap_disp", 32'(disp()), 32'h0000);
    check("wrap_ovf", 32'(bus.overflow), 32'd1);
    check("wrap_state", 32'(bus.state_dbg), 32'(RUNNING));
    step(1'b0);
    check("ovf_one_cycle", 32'(bus.overflow), 32'd0);

    // Stopped at 02:03: simultaneous start + clear -> clear wins.
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    ticks(123);
    press(1'b1, 1'b0, 1'b0);
    check("stop_0203", 32'(disp()), 32'h0203);
    bus.start_stop_btn = 1'b1; bus.clear_btn = 1'b1;
    step(1'b0);
    check("both_state", 32'(bus.state_dbg), 32'(IDLE));
    check("both_disp", 32'(disp()), 32'h0000);
    check("both_nclr", 32'(bus.timer_n_clr), 32'd0);
    bus.start_stop_btn = 1'b0; bus.clear_btn = 1'b0;
    step(1'b0);

    // Start held through reset release: no start.
    bus.start_stop_btn = 1'b1;
    n_rst = 1'b0;
    step(1'b0);
    step(1'b0);
    n_rst = 1'b1;
    step(1'b0);
    step(1'b1);
    check("held_btn_state", 32'(bus.state_dbg), 32'(IDLE));
    check("held_btn_en", 32'(bus.timer_enable), 32'd0);
    bus.start_stop_btn = 1'b0;
    step(1'b0);

    // Reset while in LAP at 00:42.
    press(1'b1, 1'b0, 1'b0);
    ticks(42);
    press(1'b0, 1'b0, 1'b1);
    check("lap42_disp", 32'(disp()), 32'h0042);
    n_rst = 1'b0;
    step(1'b1);
    check("rst_lap_state", 32'(bus.state_dbg), 32'(IDLE));
    check("rst_lap_disp", 32'(disp()), 32'h0000);
    check("rst_lap_hold", 32'(bus.lap_hold), 32'd0);
    n_rst = 1'b1;
    step(1'b0);

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.start_stop_btn = ~bus.start_stop_btn;
      if ($urandom_range(0, 9) == 0) bus.clear_btn      = ~bus.clear_btn;
      if ($urandom_range(0, 7) == 0) bus.lap_btn        = ~bus.lap_btn;
      n_rst = ($urandom_range(0, 299) != 0);
      step(1'($urandom_range(0, 1)));
    end
    n_rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
